// File: rtl/cpu_isa_pkg.sv
// rtl/cpu_isa_pkg.sv - shared 8-bit ISA field positions, opcodes and issue-buffer state encoding
package cpu_isa_pkg;

  localparam int MODE_BIT = 7;
  localparam int OPC_HI   = 6;
  localparam int OPC_LO   = 4;
  localparam int RA_HI    = 3;
  localparam int RB_HI    = 1;

  localparam logic [2:0] OPC_ADD = 3'b001;
  localparam logic [2:0] OPC_INC = 3'b011;

  typedef enum logic [1:0] {
    LOAD  = 2'b00,
    ISSUE = 2'b01,
    DONE  = 2'b10
  } issue_state_e;

endpackage

// File: rtl/instr_legal_check.sv
// rtl/instr_legal_check.sv - combinational legality predicate for an 8-bit instruction word
module instr_legal_check
  import cpu_isa_pkg::*;
(
  input  logic [7:0] instr,
  output logic       legal
);

  logic [2:0] opc;
  logic       unused_regs;

  assign opc   = instr[OPC_HI:OPC_LO];
  assign legal = !instr[MODE_BIT] && ((opc == OPC_ADD) || (opc == OPC_INC));

  // register fields never affect legality
  assign unused_regs = ^instr[RA_HI:0];

endmodule

// File: rtl/instr_issue_buffer.sv
// rtl/instr_issue_buffer.sv - program buffer feeding the CPU fetch stage; legality filter under INSTR_ISSUE_CHECK_EN
module instr_issue_buffer
  import cpu_isa_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clock_pulse,
  input  logic             resetn,
  input  logic             load_valid,
  input  logic [7:0]       load_instr,
  output logic             load_ready,
  input  logic             run,
  input  logic             clear,
  input  logic             fetch_ack,
  output logic [7:0]       instr_out,
  output logic             instr_valid,
  output logic [PTR_W-1:0] pc,
  output logic [PTR_W:0]   count,
  output logic             halted,
  output logic             load_err
);

  localparam int CW = PTR_W + 1;

  issue_state_e state, next_state;

  logic [7:0]       mem [DEPTH];
  logic             word_legal;
  logic             accept;
  logic             store;
  logic             run_go;
  logic             ack;
  logic             last;
  logic [PTR_W-1:0] pc_inc;
  logic [PTR_W:0]   pc_plus1;

`ifdef INSTR_ISSUE_CHECK_EN
  logic load_err_q;

  instr_legal_check u_legal_check (
    .instr (load_instr),
    .legal (word_legal)
  );

  always_ff @(posedge clock_pulse or negedge resetn) begin
    if (!resetn) load_err_q <= 1'b0;
    else         load_err_q <= !clear && accept && !word_legal;
  end

  assign load_err = load_err_q;
`else
  assign word_legal = 1'b1;
  assign load_err   = 1'b0;
`endif

  assign load_ready  = (state == LOAD) && (count < CW'(DEPTH));
  assign accept      = load_valid && load_ready;
  assign store       = accept && word_legal;
  // a word stored on the same edge as run counts toward the program
  assign run_go      = run && ((count != '0) || store);
  assign instr_valid = (state == ISSUE);
  assign halted      = (state == DONE);
  assign ack         = fetch_ack && instr_valid;
  assign pc_inc      = pc + PTR_W'(1);
  assign pc_plus1    = {1'b0, pc} + CW'(1);
  assign last        = (pc_plus1 >= count);

  always_ff @(posedge clock_pulse or negedge resetn) begin
    if (!resetn) state <= LOAD;
    else         state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (clear) begin
      next_state = LOAD;
    end else begin
      case (state)
        LOAD:    if (run_go) next_state = ISSUE;
        ISSUE:   if (ack && last) next_state = DONE;
        DONE:    if (run) next_state = ISSUE;
        default: next_state = LOAD;
      endcase
    end
  end

  always_ff @(posedge clock_pulse or negedge resetn) begin
    if (!resetn) begin
      count     <= '0;
      pc        <= '0;
      instr_out <= 8'h00;
    end else if (clear) begin
      count <= '0;
      pc    <= '0;
    end else begin
      case (state)
        LOAD: begin
          if (store) count <= count + CW'(1);
          if (run_go) begin
            pc        <= '0;
            // empty buffer: the word being written this edge is slot 0
            instr_out <= (count == '0) ? load_instr : mem[0];
          end
        end
        ISSUE: begin
          if (ack && !last) begin
            pc        <= pc_inc;
            instr_out <= mem[pc_inc];
          end
        end
        DONE: begin
          if (run) begin
            pc        <= '0;
            instr_out <= mem[0];
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock_pulse) begin
    if (!clear && store) mem[count[PTR_W-1:0]] <= load_instr;
  end

endmodule
